// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (instruction/data) to one Avalon-style master memory arbiter
module mem_arbiter #(
    parameter int ROUND_ROBIN = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_done,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_done,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    output logic [3:0]  byteenable,
    output logic [31:0] writedata,
    input  logic [31:0] readdata,
    input  logic        waitrequest
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RESP  = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    logic [1:0]  state_q, state_d;
    logic        port_q, port_d;
    logic        last_grant_q, last_grant_d;
    logic [31:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [3:0]  byteenable_q, byteenable_d;
    logic [31:0] writedata_q, writedata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        i_done_q, i_done_d;
    logic        d_done_q, d_done_d;

    logic i_want, d_want, grant_data;

    // A port whose done is high this cycle is still holding its old request.
    assign i_want     = i_req & ~i_done_q;
    assign d_want     = (d_read | d_write) & ~d_done_q;
    assign grant_data = d_want & (~i_want | (ROUND_ROBIN == 0) | (last_grant_q == PORT_I));

    always_comb begin
        state_d      = state_q;
        port_d       = port_q;
        last_grant_d = last_grant_q;
        address_d    = address_q;
        read_d       = read_q;
        write_d      = write_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        i_done_d     = 1'b0;
        d_done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    state_d      = ST_ISSUE;
                    port_d       = PORT_D;
                    last_grant_d = PORT_D;
                    address_d    = d_addr;
                    byteenable_d = d_byteenable;
                    writedata_d  = d_wdata;
                    write_d      = d_write;
                    read_d       = ~d_write;
                end else if (i_want) begin
                    state_d      = ST_ISSUE;
                    port_d       = PORT_I;
                    last_grant_d = PORT_I;
                    address_d    = i_addr;
                    byteenable_d = 4'hF;
                    write_d      = 1'b0;
                    read_d       = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (!waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    if (write_q) begin
                        d_done_d = 1'b1;
                        state_d  = ST_IDLE;
                    end else begin
                        state_d  = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (port_q == PORT_D) begin
                    d_rdata_d = readdata;
                    d_done_d  = 1'b1;
                end else begin
                    i_rdata_d = readdata;
                    i_done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            port_q       <= PORT_D;
            last_grant_q <= PORT_D;
            address_q    <= 32'd0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            byteenable_q <= 4'd0;
            writedata_q  <= 32'd0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
            i_done_q     <= 1'b0;
            d_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            port_q       <= port_d;
            last_grant_q <= last_grant_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            i_done_q     <= i_done_d;
            d_done_q     <= d_done_d;
        end
    end

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign byteenable = byteenable_q;
    assign writedata  = writedata_q;
    assign i_rdata    = i_rdata_q;
    assign d_rdata    = d_rdata_q;
    assign i_done     = i_done_q;
    assign d_done     = d_done_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (instance 0 round-robin, instance 1 fixed priority)
module tb_mem_arbiter;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] data;
    } acc_t;

    logic        clk;
    logic [1:0]  rst, i_req, i_done, d_read, d_write, d_done, read, write, waitrequest;
    logic [31:0] i_addr [2];
    logic [31:0] i_rdata [2];
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];
    logic [31:0] d_rdata [2];
    logic [31:0] address [2];
    logic [31:0] writedata [2];
    logic [31:0] readdata [2];
    logic [3:0]  d_be [2];
    logic [3:0]  byteenable [2];

    acc_t        exp_acc [2][$];
    acc_t        exp_d [2][$];
    logic [31:0] exp_i [2][$];
    logic [31:0] last_d [2];

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.ROUND_ROBIN(1)) u_rr (
        .clk(clk), .reset(rst[0]),
        .i_req(i_req[0]), .i_addr(i_addr[0]), .i_rdata(i_rdata[0]), .i_done(i_done[0]),
        .d_read(d_read[0]), .d_write(d_write[0]), .d_byteenable(d_be[0]), .d_addr(d_addr[0]),
        .d_wdata(d_wdata[0]), .d_rdata(d_rdata[0]), .d_done(d_done[0]),
        .address(address[0]), .read(read[0]), .write(write[0]), .byteenable(byteenable[0]),
        .writedata(writedata[0]), .readdata(readdata[0]), .waitrequest(waitrequest[0])
    );

    mem_arbiter #(.ROUND_ROBIN(0)) u_fixed (
        .clk(clk), .reset(rst[1]),
        .i_req(i_req[1]), .i_addr(i_addr[1]), .i_rdata(i_rdata[1]), .i_done(i_done[1]),
        .d_read(d_read[1]), .d_write(d_write[1]), .d_byteenable(d_be[1]), .d_addr(d_addr[1]),
        .d_wdata(d_wdata[1]), .d_rdata(d_rdata[1]), .d_done(d_done[1]),
        .address(address[1]), .read(read[1]), .write(write[1]), .byteenable(byteenable[1]),
        .writedata(writedata[1]), .readdata(readdata[1]), .waitrequest(waitrequest[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (a == 32'hBFC00000) return 32'h24020005;
        return {a[15:0], ~a[31:16]};
    endfunction

    // RAM model: registered read data one cycle after acceptance, garbage otherwise
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (read[k] && !waitrequest[k]) readdata[k] <= mem_fn(address[k]);
            else                            readdata[k] <= 32'hBAD0BAD0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    task automatic push_acc(input int k, input logic we, input logic [31:0] a,
                            input logic [3:0] be, input logic [31:0] wd);
        acc_t e;
        e.we = we; e.addr = a; e.be = be; e.data = wd;
        exp_acc[k].push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever a transfer is accepted or a done pulses
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            acc_t e;
            if (!rst[k]) last_d[k] = 32'd0;
            chk("done_excl", 32'(i_done[k] & d_done[k]), 32'd0);
            chk("rw_excl", 32'(read[k] & write[k]), 32'd0);
            if ((read[k] || write[k]) && !waitrequest[k]) begin
                if (exp_acc[k].size() == 0) begin
                    chk("acc_unexpected_addr", address[k], 32'hFFFFFFFF);
                end else begin
                    e = exp_acc[k].pop_front();
                    chk("acc_we", 32'(write[k]), 32'(e.we));
                    chk("acc_addr", address[k], e.addr);
                    chk("acc_be", 32'(byteenable[k]), 32'(e.be));
                    if (e.we) chk("acc_wdata", writedata[k], e.data);
                end
            end
            if (i_done[k]) begin
                if (exp_i[k].size() == 0) chk("i_done_unexpected", i_rdata[k], 32'hFFFFFFFF);
                else chk("i_rdata", i_rdata[k], exp_i[k].pop_front());
            end
            if (d_done[k]) begin
                if (exp_d[k].size() == 0) begin
                    chk("d_done_unexpected", d_rdata[k], 32'hFFFFFFFF);
                end else begin
                    e = exp_d[k].pop_front();
                    if (e.we) begin
                        chk("d_rdata_hold", d_rdata[k], last_d[k]);
                    end else begin
                        chk("d_rdata", d_rdata[k], e.data);
                        last_d[k] = e.data;
                    end
                end
            end
        end
    end

    task automatic i_read(input int k, input logic [31:0] a, output int lat);
        i_addr[k] = a;
        i_req[k]  = 1'b1;
        exp_i[k].push_back(mem_fn(a));
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!i_done[k] && lat < 60);
        if (!i_done[k]) timeout("i_read");
        lat = lat - 1;
    endtask

    task automatic d_op(input int k, input logic we, input logic [31:0] a, input logic [3:0] be,
                        input logic [31:0] wd, output int lat);
        acc_t e;
        d_addr[k]  = a;
        d_be[k]    = be;
        d_wdata[k] = wd;
        d_write[k] = we;
        d_read[k]  = ~we;
        e.we = we; e.addr = a; e.be = be; e.data = we ? 32'd0 : mem_fn(a);
        exp_d[k].push_back(e);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!d_done[k] && lat < 60);
        if (!d_done[k]) timeout("d_op");
        lat = lat - 1;
    endtask

    task automatic wait_neg(input int k, input logic want_i_done, input string nm);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(want_i_done ? i_done[k] : (read[k] | write[k])) && n < 60);
        if (n >= 60) timeout(nm);
    endtask

    initial begin
        int la, lb;
        rst = 2'b00; i_req = 2'b00; d_read = 2'b00; d_write = 2'b00; waitrequest = 2'b00;
        for (int k = 0; k < 2; k++) begin
            i_addr[k] = 32'd0; d_addr[k] = 32'd0; d_wdata[k] = 32'd0; d_be[k] = 4'd0;
            last_d[k] = 32'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_read", 32'(read[0]), 32'd0);
        chk("rst_write", 32'(write[0]), 32'd0);
        chk("rst_i_done", 32'(i_done[0]), 32'd0);
        chk("rst_d_done", 32'(d_done[0]), 32'd0);
        chk("rst_address", address[0], 32'd0);
        chk("rst_be", 32'(byteenable[0]), 32'd0);
        chk("rst_wdata", writedata[0], 32'd0);
        chk("rst_i_rdata", i_rdata[0], 32'd0);
        chk("rst_d_rdata", d_rdata[1], 32'd0);
        @(posedge clk); #1 rst = 2'b11;
        @(posedge clk); #1;

        // boot fetch, latency 3, single-cycle read strobe
        push_acc(0, 1'b0, 32'hBFC00000, 4'hF, 32'd0);
        fork
            i_read(0, 32'hBFC00000, la);
            begin
                @(negedge clk);
                @(negedge clk);
                chk("t1_read_hi", 32'(read[0]), 32'd1);
                chk("t1_addr", address[0], 32'hBFC00000);
                chk("t1_be", 32'(byteenable[0]), 32'hF);
                @(negedge clk);
                chk("t1_read_lo", 32'(read[0]), 32'd0);
            end
        join
        i_req[0] = 1'b0;
        chk("t1_latency", 32'(la), 32'd3);
        @(posedge clk); #1;

        // stalled write: outputs stable four cycles, done one cycle after acceptance
        waitrequest[0] = 1'b1;
        push_acc(0, 1'b1, 32'hBFC00100, 4'b0011, 32'hDEADBEEF);
        fork
            d_op(0, 1'b1, 32'hBFC00100, 4'b0011, 32'hDEADBEEF, la);
            begin
                wait_neg(0, 1'b0, "t2_write_start");
                for (int j = 0; j < 4; j++) begin
                    chk("t2_write_hi", 32'(write[0]), 32'd1);
                    chk("t2_addr", address[0], 32'hBFC00100);
                    chk("t2_wdata", writedata[0], 32'hDEADBEEF);
                    chk("t2_be", 32'(byteenable[0]), 32'h3);
                    if (j == 2) begin
                        @(posedge clk); #1 waitrequest[0] = 1'b0;
                    end
                    @(negedge clk);
                end
                chk("t2_write_lo", 32'(write[0]), 32'd0);
                chk("t2_d_done", 32'(d_done[0]), 32'd1);
                chk("t2_i_done", 32'(i_done[0]), 32'd0);
            end
        join
        d_write[0] = 1'b0;
        chk("t2_latency", 32'(la), 32'd5);
        @(posedge clk); #1;

        // unstalled write latency
        push_acc(0, 1'b1, 32'h00000040, 4'b1100, 32'h0BADF00D);
        d_op(0, 1'b1, 32'h00000040, 4'b1100, 32'h0BADF00D, la);
        d_write[0] = 1'b0;
        chk("write_latency", 32'(la), 32'd2);
        @(posedge clk); #1;

        // contention, round robin: I, D, I, D
        push_acc(0, 1'b0, 32'h00001000, 4'hF, 32'd0);
        push_acc(0, 1'b0, 32'h00002000, 4'hF, 32'd0);
        push_acc(0, 1'b0, 32'h00001004, 4'hF, 32'd0);
        push_acc(0, 1'b0, 32'h00002004, 4'hF, 32'd0);
        fork
            begin i_read(0, 32'h00001000, la); i_read(0, 32'h00001004, la); i_req[0] = 1'b0; end
            begin
                d_op(0, 1'b0, 32'h00002000, 4'hF, 32'd0, lb);
                d_op(0, 1'b0, 32'h00002004, 4'hF, 32'd0, lb);
                d_read[0] = 1'b0;
            end
        join
        @(posedge clk); #1;

        // contention, fixed data priority: D, I, D, I
        push_acc(1, 1'b0, 32'h00002000, 4'hF, 32'd0);
        push_acc(1, 1'b0, 32'h00001000, 4'hF, 32'd0);
        push_acc(1, 1'b0, 32'h00002004, 4'hF, 32'd0);
        push_acc(1, 1'b0, 32'h00001004, 4'hF, 32'd0);
        fork
            begin i_read(1, 32'h00001000, la); i_read(1, 32'h00001004, la); i_req[1] = 1'b0; end
            begin
                d_op(1, 1'b0, 32'h00002000, 4'hF, 32'd0, lb);
                d_op(1, 1'b0, 32'h00002004, 4'hF, 32'd0, lb);
                d_read[1] = 1'b0;
            end
        join
        @(posedge clk); #1;

        // reset during a stalled issue aborts it; request re-issued afterwards
        waitrequest[0] = 1'b1;
        push_acc(0, 1'b0, 32'h30000010, 4'hF, 32'd0);
        fork
            d_op(0, 1'b0, 32'h30000010, 4'hF, 32'd0, la);
            begin
                wait_neg(0, 1'b0, "t5_issue");
                @(posedge clk); #1 rst[0] = 1'b0;
                @(negedge clk);
                @(negedge clk);
                chk("t5_read", 32'(read[0]), 32'd0);
                chk("t5_write", 32'(write[0]), 32'd0);
                chk("t5_i_done", 32'(i_done[0]), 32'd0);
                chk("t5_d_done", 32'(d_done[0]), 32'd0);
                @(posedge clk); #1;
                rst[0] = 1'b1;
                waitrequest[0] = 1'b0;
            end
        join
        d_read[0] = 1'b0;
        @(posedge clk); #1;

        // i_req held through i_done: no re-issue in the done cycle
        push_acc(0, 1'b0, 32'h00000400, 4'hF, 32'd0);
        push_acc(0, 1'b0, 32'h00000404, 4'hF, 32'd0);
        fork
            begin i_read(0, 32'h00000400, la); i_read(0, 32'h00000404, la); i_req[0] = 1'b0; end
            begin
                wait_neg(0, 1'b1, "t6_done");
                @(negedge clk);
                chk("t6_no_reissue", 32'(read[0]), 32'd0);
                @(negedge clk);
                chk("t6_next_read", 32'(read[0]), 32'd1);
                chk("t6_next_addr", address[0], 32'h00000404);
            end
        join

        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk("sb_acc_empty", 32'(exp_acc[k].size()), 32'd0);
            chk("sb_i_empty", 32'(exp_i[k].size()), 32'd0);
            chk("sb_d_empty", 32'(exp_d[k].size()), 32'd0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
